fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Program-counter register and next-PC selector for the IF stage of the 5-stage MIPS pipeline.
- Consumes the ID-stage branch decision (comparator result plus decoded branch/jump controls) and redirects fetch with one delay slot.
- Honours hazard-unit stalls.
- Keeps saturating branch statistics and flags fetch-address faults for the exception logic.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded by reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_WORDS, 4096, instruction memory size in words; legal range is [IMEM_BASE, IMEM_BASE+4*IMEM_WORDS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
- stall  in  1  hazard-unit freeze; PC holds.
- cmp_out  in  1  branch-condition result from the ID-stage comparator (1 = condition true).
- branch_id  in  1  instruction in ID is a conditional branch.
- jump_id  in  1  instruction in ID is j/jal.
- jr_id  in  1  instruction in ID is jr/jalr.
- pc_id  in  32  PC of the instruction in ID.
- imm16  in  16  branch offset field of the ID instruction.
- index26  in  26  jump index field of the ID instruction.
- jr_target  in  32  forwarded rs value for jr/jalr.
- pc  out  32  current fetch address (registered).
- redirect  out  1  registered; 1 for the cycle after pc was loaded from a branch/jump target.
- fetch_fault  out  1  registered; pc misaligned or outside the legal range.
- ctrl_conflict  out  1  sticky; more than one of branch_id/jump_id/jr_id seen high while not stalled.
- br_total  out  32  conditional branches retired from ID, saturating.
- br_taken  out  32  taken conditional branches, saturating.

Behaviour:
- Reset (reset==0 at a clock edge):
  - pc=RESET_PC.
  - redirect=0, fetch_fault=0, ctrl_conflict=0, br_total=0, br_taken=0.
  - State=BOOT.
  - Reset overrides stall and all controls.
  - Reset asserted mid-operation takes effect at the next edge with no partial update.
- FSM states and transitions:
  - BOOT: one cycle; pc holds RESET_PC; controls ignored; counters frozen. Unconditional transition to RUN.
  - RUN: stall=1 -> STALL with no pc update. Else pc<=next_pc.
  - STALL: stall=1 -> stay, pc and counters hold, redirect=0. stall=0 -> evaluate next_pc that same cycle and go to RUN; the ID instruction is re-presented, so this is its single evaluation.
- next_pc priority, evaluated only when an update is permitted (RUN or STALL exiting, stall=0):
  1. jr_id: jr_target.
  2. jump_id: {pc_id[31:28], index26, 2'b00}.
  3. branch_id && cmp_out: pc_id + 4 + ({{14{imm16[15]}}, imm16, 2'b00}); 32-bit wrap-around, no overflow detection.
  4. Otherwise: pc + 4, wrapping at 2^32.
- Delay slot: the instruction at pc_id+4 is already being fetched when the redirect is computed; it is never squashed. A target takes effect with 1-cycle latency (pc updated at the edge ending the decision cycle).
- redirect <= 1 when priority case 1, 2 or 3 loaded pc; else 0.
- fetch_fault is combinationally derived from the newly loaded pc and registered with it: pc[1:0]!=0, or pc<IMEM_BASE, or pc>=IMEM_BASE+4*IMEM_WORDS. The faulting pc is still loaded; the fault clears when a legal pc loads.
- ctrl_conflict is set at the update edge and stays set until reset; the priority rule still governs next_pc.
- Counters, updated only at update edges:
  - br_total +1 when branch_id=1.
  - br_taken +1 when branch_id=1 and cmp_out=1 and neither jr_id nor jump_id is high.
  - Both hold at 32'hFFFF_FFFF once reached.
- cmp_out is ignored when branch_id=0.

Test Plan:
- Hold reset=0 two cycles, then release -> pc=0x3000 for the BOOT cycle and the following cycle; next edges 0x3004, 0x3008; redirect=0; counters 0.
- pc_id=0x3010, branch_id=1, cmp_out=1, imm16=0xFFFC -> pc=0x3004 next cycle; redirect=1; br_total=1, br_taken=1. Same with cmp_out=0 -> pc=pc+4; br_taken unchanged.
- jump_id=1, pc_id=0x3020, index26=0x0000C40 -> pc=0x3100. jr_id=1 with jr_target=0x3002 -> pc=0x3002, fetch_fault=1; next sequential load clears it only once aligned and in range.
- stall=1 for 3 cycles with branch_id=1, cmp_out=1 -> pc frozen, counters frozen; stall drops -> single redirect, br_total +1 exactly once.
- branch_id=1 and jr_id=1 together -> jr_target wins; ctrl_conflict=1 and stays set; br_taken unchanged.
- Preload via repeated branches until br_total=0xFFFF_FFFF -> further branches leave it at 0xFFFF_FFFF. Reset asserted mid-stall -> pc=0x3000, all flags and counters 0.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// ID-stage redirect bundle and fetch status for the IF-stage PC unit.
// The pipeline side drives decisions (master); the PC unit answers with fetch state (slave).
interface fetch_pc_unit_if;
   logic        stall;
   logic        cmp_out;
   logic        branch_id;
   logic        jump_id;
   logic        jr_id;
   logic [31:0] pc_id;
   logic [15:0] imm16;
   logic [25:0] index26;
   logic [31:0] jr_target;

   logic [31:0] pc;
   logic        redirect;
   logic        fetch_fault;
   logic        ctrl_conflict;
   logic [31:0] br_total;
   logic [31:0] br_taken;

   modport master (
      output stall, cmp_out, branch_id, jump_id, jr_id, pc_id, imm16, index26, jr_target,
      input  pc, redirect, fetch_fault, ctrl_conflict, br_total, br_taken
   );

   modport slave (
      input  stall, cmp_out, branch_id, jump_id, jr_id, pc_id, imm16, index26, jr_target,
      output pc, redirect, fetch_fault, ctrl_conflict, br_total, br_taken
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// IF-stage program counter with one-delay-slot redirect from ID, stall handling,
// fetch-address fault flag and saturating branch statistics.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
   parameter int unsigned IMEM_WORDS = 4096
) (
   input  logic             clk,
   input  logic             reset,
   fetch_pc_unit_if.slave   bus
);

   // One past the last legal byte address; 33 bits so a top-of-space memory cannot wrap.
   localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

   typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic        redirect_q;
   logic        fault_q;
   logic        conflict_q;
   logic [31:0] br_total_q;
   logic [31:0] br_taken_q;

   logic        upd;
   logic [31:0] next_pc;
   logic        take_target;
   logic        fault_d;
   logic        conflict_d;
   logic        br_hit;
   logic [31:0] br_offset;

   assign br_offset = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      upd     = 1'b0;
      unique case (state_q)
         BOOT:  state_d = RUN;
         RUN: begin
            if (bus.stall) state_d = STALL;
            else           upd     = 1'b1;
         end
         STALL: begin
            if (!bus.stall) begin
               state_d = RUN;
               upd     = 1'b1;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      next_pc     = pc_q + 32'd4;
      take_target = 1'b1;
      br_hit      = bus.branch_id && bus.cmp_out;
      if (bus.jr_id)        next_pc = bus.jr_target;
      else if (bus.jump_id) next_pc = {bus.pc_id[31:28], bus.index26, 2'b00};
      else if (br_hit)      next_pc = bus.pc_id + 32'd4 + br_offset;
      else                  take_target = 1'b0;

      fault_d    = (next_pc[1:0] != 2'b00) || (next_pc < IMEM_BASE) ||
                   ({1'b0, next_pc} >= IMEM_END);
      conflict_d = (bus.branch_id && bus.jump_id) || (bus.branch_id && bus.jr_id) ||
                   (bus.jump_id && bus.jr_id);
   end

   // NOTE: clocked state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= BOOT;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         redirect_q <= 1'b0;
         fault_q    <= 1'b0;
         conflict_q <= 1'b0;
         br_total_q <= '0;
         br_taken_q <= '0;
      end else if (upd) begin
         pc_q       <= next_pc;
         redirect_q <= take_target;
         fault_q    <= fault_d;
         if (conflict_d) conflict_q <= 1'b1;
         if (bus.branch_id && br_total_q != '1) br_total_q <= br_total_q + 32'd1;
         // A jump or jr in the same slot wins the redirect, so the branch is not counted taken.
         if (br_hit && !bus.jr_id && !bus.jump_id && br_taken_q != '1)
            br_taken_q <= br_taken_q + 32'd1;
      end else begin
         redirect_q <= 1'b0;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.redirect      = redirect_q;
   assign bus.fetch_fault   = fault_q;
   assign bus.ctrl_conflict = conflict_q;
   assign bus.br_total      = br_total_q;
   assign bus.br_taken      = br_taken_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset/boot, branches, jumps, faults, stalls,
// control conflicts, counter saturation and reset during stall.
module tb_fetch_pc_unit;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   fetch_pc_unit_if bus ();

   fetch_pc_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctrl();
      bus.stall     = 1'b0;
      bus.cmp_out   = 1'b0;
      bus.branch_id = 1'b0;
      bus.jump_id   = 1'b0;
      bus.jr_id     = 1'b0;
      bus.pc_id     = 32'h0;
      bus.imm16     = 16'h0;
      bus.index26   = 26'h0;
      bus.jr_target = 32'h0;
   endtask

   task automatic check_state(input string tag, input logic [31:0] pc, input logic redir,
                              input logic fault, input logic conflict,
                              input logic [31:0] total, input logic [31:0] taken);
      check({tag, ".pc"},       bus.pc,                     pc);
      check({tag, ".redirect"}, {31'b0, bus.redirect},      {31'b0, redir});
      check({tag, ".fault"},    {31'b0, bus.fetch_fault},   {31'b0, fault});
      check({tag, ".conflict"}, {31'b0, bus.ctrl_conflict}, {31'b0, conflict});
      check({tag, ".br_total"}, bus.br_total,               total);
      check({tag, ".br_taken"}, bus.br_taken,               taken);
   endtask

   initial begin
      idle_ctrl();
      reset = 1'b0;
      #2;
      step();
      step();
      check_state("reset", 32'h3000, 0, 0, 0, 0, 0);

      reset = 1'b1;
      step();
      check_state("boot", 32'h3000, 0, 0, 0, 0, 0);
      step();
      check_state("seq1", 32'h3004, 0, 0, 0, 0, 0);
      step();
      check_state("seq2", 32'h3008, 0, 0, 0, 0, 0);

      // Backward branch: 0x3010 + 4 - 16 = 0x3004
      bus.pc_id = 32'h3010; bus.branch_id = 1'b1; bus.cmp_out = 1'b1; bus.imm16 = 16'hFFFC;
      step();
      check_state("br_taken", 32'h3004, 1, 0, 0, 1, 1);
      bus.cmp_out = 1'b0;
      step();
      check_state("br_not_taken", 32'h3008, 0, 0, 0, 2, 1);

      idle_ctrl();
      bus.jump_id = 1'b1; bus.pc_id = 32'h3020; bus.index26 = 26'h0000C40;
      step();
      check_state("jump", 32'h3100, 1, 0, 0, 2, 1);

      idle_ctrl();
      bus.jr_id = 1'b1; bus.jr_target = 32'h3002;
      step();
      check_state("jr_misaligned", 32'h3002, 1, 1, 0, 2, 1);
      idle_ctrl();
      step();
      check_state("seq_misaligned", 32'h3006, 0, 1, 0, 2, 1);

      bus.jr_id = 1'b1; bus.jr_target = 32'h6FFC;
      step();
      check_state("jr_last_word", 32'h6FFC, 1, 0, 0, 2, 1);
      idle_ctrl();
      step();
      check_state("seq_past_end", 32'h7000, 0, 1, 0, 2, 1);

      bus.jr_id = 1'b1; bus.jr_target = 32'h2FFC;
      step();
      check_state("jr_below_base", 32'h2FFC, 1, 1, 0, 2, 1);
      idle_ctrl();
      step();
      check_state("seq_to_base", 32'h3000, 0, 0, 0, 2, 1);

      // Stall three cycles with a taken branch waiting in ID.
      bus.stall = 1'b1; bus.pc_id = 32'h3010; bus.branch_id = 1'b1; bus.cmp_out = 1'b1;
      bus.imm16 = 16'hFFFC;
      for (int i = 0; i < 3; i++) begin
         step();
         check_state($sformatf("stall%0d", i), 32'h3000, 0, 0, 0, 2, 1);
      end
      bus.stall = 1'b0;
      step();
      check_state("stall_exit", 32'h3004, 1, 0, 0, 3, 2);
      idle_ctrl();
      step();
      check_state("after_stall", 32'h3008, 0, 0, 0, 3, 2);

      // Branch and jr together: jr wins, conflict latches, branch counted but not taken.
      bus.branch_id = 1'b1; bus.cmp_out = 1'b1; bus.pc_id = 32'h3010; bus.imm16 = 16'hFFFC;
      bus.jr_id = 1'b1; bus.jr_target = 32'h3040;
      step();
      check_state("conflict", 32'h3040, 1, 0, 1, 4, 2);
      idle_ctrl();
      step();
      check_state("conflict_sticky", 32'h3044, 0, 0, 1, 4, 2);

      // Preload counters near the top instead of billions of branches.
      dut.br_total_q = 32'hFFFF_FFFE;
      dut.br_taken_q = 32'hFFFF_FFFE;
      bus.branch_id = 1'b1; bus.cmp_out = 1'b1; bus.pc_id = 32'h3010; bus.imm16 = 16'hFFFC;
      step();
      check_state("sat_reach", 32'h3004, 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      check_state("sat_hold", 32'h3004, 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Reset while frozen in STALL.
      idle_ctrl();
      bus.stall = 1'b1;
      step();
      check("stall_pre_reset.pc", bus.pc, 32'h3004);
      reset = 1'b0;
      bus.branch_id = 1'b1; bus.cmp_out = 1'b1; bus.jr_id = 1'b1; bus.jr_target = 32'h5000;
      step();
      check_state("reset_mid_stall", 32'h3000, 0, 0, 0, 0, 0);
      reset = 1'b1;
      idle_ctrl();
      step();
      check_state("reboot", 32'h3000, 0, 0, 0, 0, 0);
      step();
      check_state("reboot_seq", 32'h3004, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
